// File: rtl/dump_memoria_datos_if.sv
// Signal bundle between the data-memory dump sequencer and its environment
// (data memory, dirty-bit control, debug unit and UART transmitter).
interface dump_memoria_datos_if #(
    parameter int ADDR_MEM_LENGTH    = 10,
    parameter int RAM_WIDTH          = 32,
    parameter int OUTPUT_WORD_LENGTH = 8
);
    logic                          i_start;
    logic [RAM_WIDTH-1:0]          i_dato_mem;
    logic                          i_bit_sucio;
    logic                          i_tx_done;
    logic [ADDR_MEM_LENGTH-1:0]    o_addr;
    logic                          o_tx_start;
    logic [OUTPUT_WORD_LENGTH-1:0] o_data_tx;
    logic                          o_busy;
    logic                          o_done;

    // The sequencer is the master: it owns the address bus and the tx request.
    modport master (
        input  i_start, i_dato_mem, i_bit_sucio, i_tx_done,
        output o_addr, o_tx_start, o_data_tx, o_busy, o_done
    );

    modport slave (
        output i_start, i_dato_mem, i_bit_sucio, i_tx_done,
        input  o_addr, o_tx_start, o_data_tx, o_busy, o_done
    );
endinterface

// File: rtl/dump_memoria_datos.sv
// Walks every data-memory address and sends addr+data packets for dirty words
// over the UART, followed by a two-byte 0xFF end marker.
module dump_memoria_datos #(
    parameter int RAM_DEPTH          = 1024,
    parameter int ADDR_MEM_LENGTH    = 10,
    parameter int RAM_WIDTH          = 32,
    parameter int OUTPUT_WORD_LENGTH = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    dump_memoria_datos_if.master        bus
);
    localparam int N_BYTES = 2 + RAM_WIDTH / 8;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam logic [ADDR_MEM_LENGTH-1:0]    LAST_ADDR = ADDR_MEM_LENGTH'(RAM_DEPTH - 1);
    localparam logic [IDX_W-1:0]              LAST_IDX  = IDX_W'(N_BYTES - 1);
    localparam logic [OUTPUT_WORD_LENGTH-1:0] MARKER    = OUTPUT_WORD_LENGTH'(8'hFF);

    typedef enum logic [2:0] {
        IDLE, SET_ADDR, CAPTURE, SEND, WAIT_TX, END_SEND, END_WAIT, DONE
    } state_t;

    state_t                     state;
    logic [ADDR_MEM_LENGTH-1:0] addr;
    logic [RAM_WIDTH-1:0]       word;
    logic [IDX_W-1:0]           idx;
    logic                       tx_done_prev;
    logic                       tx_fin;

    // Only a rising edge of tx_done completes a byte; a stuck-high level does not.
    assign tx_fin = bus.i_tx_done & ~tx_done_prev;

    // Byte i of the packet: 16-bit address MSB first, then the word MSB first.
    function automatic logic [7:0] packet_byte(
        input logic [ADDR_MEM_LENGTH-1:0] a,
        input logic [RAM_WIDTH-1:0]       w,
        input logic [IDX_W-1:0]           i
    );
        logic [15:0]          a16;
        logic [RAM_WIDTH-1:0] shifted;
        a16         = 16'(a);
        shifted     = '0;
        packet_byte = 8'h00;
        if (i == '0) begin
            packet_byte = a16[15:8];
        end else if (i == IDX_W'(1)) begin
            packet_byte = a16[7:0];
        end else begin
            shifted     = w << {i - IDX_W'(2), 3'b000};
            packet_byte = shifted[RAM_WIDTH-1 -: 8];
        end
    endfunction

    // NOTE: every register updates with <= so all reads in this block see the
    // pre-edge values; reset is synchronous because the control path expects it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= IDLE;
            addr           <= '0;
            word           <= '0;
            idx            <= '0;
            tx_done_prev   <= 1'b0;
            bus.o_addr     <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_data_tx  <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
        end else begin
            tx_done_prev   <= bus.i_tx_done;
            bus.o_tx_start <= 1'b0;
            bus.o_done     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        addr       <= '0;
                        bus.o_addr <= '0;
                        bus.o_busy <= 1'b1;
                        state      <= SET_ADDR;
                    end
                end

                SET_ADDR: begin
                    bus.o_addr <= addr;
                    state      <= CAPTURE;
                end

                // Memory read data and dirty bit for addr are valid in this cycle.
                CAPTURE: begin
                    word <= bus.i_dato_mem;
                    if (bus.i_bit_sucio) begin
                        idx            <= '0;
                        bus.o_tx_start <= 1'b1;
                        bus.o_data_tx  <= OUTPUT_WORD_LENGTH'(packet_byte(addr, bus.i_dato_mem, '0));
                        state          <= SEND;
                    end else if (addr != LAST_ADDR) begin
                        addr       <= addr + ADDR_MEM_LENGTH'(1);
                        bus.o_addr <= addr + ADDR_MEM_LENGTH'(1);
                        state      <= SET_ADDR;
                    end else begin
                        idx            <= '0;
                        bus.o_tx_start <= 1'b1;
                        bus.o_data_tx  <= MARKER;
                        state          <= END_SEND;
                    end
                end

                SEND: state <= WAIT_TX;

                WAIT_TX: begin
                    if (tx_fin) begin
                        if (idx != LAST_IDX) begin
                            idx            <= idx + IDX_W'(1);
                            bus.o_tx_start <= 1'b1;
                            bus.o_data_tx  <= OUTPUT_WORD_LENGTH'(packet_byte(addr, word, idx + IDX_W'(1)));
                            state          <= SEND;
                        end else if (addr != LAST_ADDR) begin
                            addr       <= addr + ADDR_MEM_LENGTH'(1);
                            bus.o_addr <= addr + ADDR_MEM_LENGTH'(1);
                            state      <= SET_ADDR;
                        end else begin
                            idx            <= '0;
                            bus.o_tx_start <= 1'b1;
                            bus.o_data_tx  <= MARKER;
                            state          <= END_SEND;
                        end
                    end
                end

                END_SEND: state <= END_WAIT;

                // idx counts the marker bytes already sent.
                END_WAIT: begin
                    if (tx_fin) begin
                        if (idx == '0) begin
                            idx            <= IDX_W'(1);
                            bus.o_tx_start <= 1'b1;
                            bus.o_data_tx  <= MARKER;
                            state          <= END_SEND;
                        end else begin
                            bus.o_done <= 1'b1;
                            bus.o_addr <= '0;
                            state      <= DONE;
                        end
                    end
                end

                DONE: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
